note_fetch_arbiter: RTL

//  Shares one note-timestamp block RAM among all note lanes. Each lane owns a fixed
//  2^PTR_W-entry region holding its ascending 16-bit hit times; lanes raise level requests,
//  the arbiter grants one per cycle round-robin, reads the RAM, and returns the timestamp on

---
 rtl/note_fetch_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/note_fetch_arbiter.sv
// Round-robin arbiter sharing one note-timestamp RAM among all note lanes.
// Optional NOTE_ARB_STATS_EN adds saturating grant/conflict counters.
module note_fetch_arbiter #(
    parameter int NUM_LANES  = 37,
    parameter int LANE_W     = 6,
    parameter int PTR_W      = 4,
    parameter int TIME_W     = 16,
    parameter int RD_LAT     = 1,
    parameter int START_TIME = 5
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        restart,
    input  logic [TIME_W-1:0]           song_time,
    input  logic [NUM_LANES-1:0]        req,
    output logic                        mem_en,
    output logic [LANE_W+PTR_W-1:0]     mem_addr,
    input  logic [TIME_W-1:0]           mem_dout,
    output logic [NUM_LANES-1:0]        avail,
    output logic [NUM_LANES*TIME_W-1:0] link,
    output logic [NUM_LANES-1:0]        lane_done,
    output logic                        running
`ifdef NOTE_ARB_STATS_EN
    ,
    output logic [15:0]                 grant_count,
    output logic [15:0]                 conflict_count
`endif
);

    // state | meaning
    // IDLE  | waiting for song_time to pass START_TIME; no grants
    // RUN   | arbitrating lane requests onto the RAM
    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    localparam logic [LANE_W:0]   NL      = (LANE_W+1)'(NUM_LANES);
    localparam logic [PTR_W-1:0]  PTR_MAX = {PTR_W{1'b1}};

    state_t                 state, state_nxt;
    logic                   time_gt;
    logic [NUM_LANES-1:0]   pending;
    logic [NUM_LANES-1:0]   elig;
    logic [PTR_W-1:0]       ptr [NUM_LANES];
    logic [LANE_W-1:0]      rr_ptr;
    logic                   found;
    logic [LANE_W-1:0]      gnt_lane;
    logic                   tag_vld  [RD_LAT];
    logic [LANE_W-1:0]      tag_lane [RD_LAT];
    logic [LANE_W-1:0]      ret_lane;

    assign running  = (state == ST_RUN);
    assign ret_lane = tag_lane[RD_LAT-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (restart) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (time_gt) state_nxt = ST_RUN;
                ST_RUN:  state_nxt = ST_RUN;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Search starts one past the last granted lane so every requester is served in turn.
    always_comb begin
        logic [LANE_W:0] cand;
        found    = 1'b0;
        gnt_lane = '0;
        for (int i = 0; i < NUM_LANES; i++)
            elig[i] = running && req[i] && !pending[i] && !avail[i];
        for (int k = 1; k <= NUM_LANES; k++) begin
            cand = {1'b0, rr_ptr} + (LANE_W+1)'(k);
            if (cand >= NL) cand = cand - NL;
            if (!found && elig[cand[LANE_W-1:0]]) begin
                found    = 1'b1;
                gnt_lane = cand[LANE_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            time_gt   <= 1'b0;
            mem_en    <= 1'b0;
            mem_addr  <= '0;
            avail     <= '0;
            link      <= '0;
            lane_done <= '0;
            pending   <= '0;
            rr_ptr    <= LANE_W'(NUM_LANES-1);
            for (int i = 0; i < NUM_LANES; i++) ptr[i] <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                tag_vld[s]  <= 1'b0;
                tag_lane[s] <= '0;
            end
        end else begin
            time_gt <= (song_time > TIME_W'(START_TIME));
            avail   <= '0;
            mem_en  <= 1'b0;
            if (restart) begin
                pending   <= '0;
                lane_done <= '0;
                for (int i = 0; i < NUM_LANES; i++) ptr[i] <= '0;
                for (int s = 0; s < RD_LAT; s++) tag_vld[s] <= 1'b0;
            end else begin
                // Tag enters alongside the registered read so it exits with the RAM data.
                tag_vld[0]  <= mem_en;
                tag_lane[0] <= mem_addr[LANE_W+PTR_W-1:PTR_W];
                for (int s = 1; s < RD_LAT; s++) begin
                    tag_vld[s]  <= tag_vld[s-1];
                    tag_lane[s] <= tag_lane[s-1];
                end
                if (tag_vld[RD_LAT-1]) begin
                    link[ret_lane*TIME_W +: TIME_W] <= mem_dout;
                    avail[ret_lane]   <= 1'b1;
                    pending[ret_lane] <= 1'b0;
                    if (ptr[ret_lane] != PTR_MAX) ptr[ret_lane] <= ptr[ret_lane] + 1'b1;
                    if (mem_dout == '0) lane_done[ret_lane] <= 1'b1;
                end
                if (found) begin
                    rr_ptr <= gnt_lane;
                    if (!lane_done[gnt_lane]) begin
                        mem_en            <= 1'b1;
                        mem_addr          <= {gnt_lane, ptr[gnt_lane]};
                        pending[gnt_lane] <= 1'b1;
                    end else begin
                        avail[gnt_lane]                 <= 1'b1;
                        link[gnt_lane*TIME_W +: TIME_W] <= '0;
                    end
                end
            end
        end
    end

`ifdef NOTE_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_count    <= '0;
            conflict_count <= '0;
        end else if (restart) begin
            grant_count    <= '0;
            conflict_count <= '0;
        end else begin
            if (found && !lane_done[gnt_lane] && grant_count != 16'hFFFF)
                grant_count <= grant_count + 16'd1;
            if (|(elig & (elig - NUM_LANES'(1))) && conflict_count != 16'hFFFF)
                conflict_count <= conflict_count + 16'd1;
        end
    end
`endif

endmodule
